dsp_multacc_nch: RTL and testbench
==================================

Name: dsp_multacc_nch

Overview:
- Parametrised N-channel multiply-accumulate DSP block; next generation of the fixed dual 10x9 MAC primitive.
- Generalises channel count and operand/accumulator widths, and adds:
  - a valid pipeline (VALID_IN/VALID_OUT),
  - per-channel coefficient banks,
  - an overflow flag,
  - optional input/output registers.
- Used as the behavioural model behind the DSP primitive mappings and directly in fabric-side MAC datapaths.

Parameters:
- NUM_CH, 2, number of independent MAC lanes sharing control.
- A_WIDTH, 10, A operand/coefficient width.
- B_WIDTH, 9, B operand width.
- Z_WIDTH, 19, per-lane output width.
- ACC_WIDTH, 32, accumulator width (>= A_WIDTH+B_WIDTH+1).
- INPUT_REG_EN, 1, 1 = register A/B/control before multiply.
- OUTPUT_REG_EN, 1, 1 = register Z/OVERFLOW/VALID_OUT.
- COEFF, all zeros, NUM_CH*4*A_WIDTH bits; lane n coefficient k at [(n*4+k)*A_WIDTH +: A_WIDTH].

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- VALID_IN  in  1  current beat's operands/controls are valid.
- A  in  NUM_CH*A_WIDTH  lane n at [n*A_WIDTH +: A_WIDTH].
- B  in  NUM_CH*B_WIDTH  lane n at [n*B_WIDTH +: B_WIDTH].
- FEEDBACK  in  3  multiplicand select: 3'b0xx = A; 3'b1kk = COEFF k.
- LOAD_ACC  in  1  1 = accumulator restarts with this product.
- UNSIGNED_A  in  1  A/coefficient unsigned when 1.
- UNSIGNED_B  in  1  B unsigned when 1.
- SUBTRACT  in  1  1 = subtract the product.
- SHIFT_RIGHT  in  6  output right-shift amount, 0..ACC_WIDTH-1.
- ROUND  in  1  round half-up before shift.
- SATURATE  in  1  clamp output to Z range.
- Z  out  NUM_CH*Z_WIDTH  per-lane result.
- DLY_B  out  NUM_CH*B_WIDTH  B delayed exactly 1 cycle, captured every cycle regardless of VALID_IN.
- VALID_OUT  out  1  Z corresponds to an accepted beat.
- OVERFLOW  out  NUM_CH  per-lane range overflow for the current Z.

Behaviour:
- Reset (RESET=0, asynchronous): all pipeline, accumulator and output registers clear. Z=0, DLY_B=0, VALID_OUT=0, OVERFLOW=0. Reset mid-accumulation discards all state; the first beat after release must use LOAD_ACC=1 to be meaningful (acc starts at 0 anyway).
- Stage 0, optional input register (INPUT_REG_EN): captures A, B, all controls and VALID_IN together. When disabled, the stage is a wire.
- Stage 1, accumulate (always registered), updates only when the stage valid is 1.
  - prod = sext/zext(mult) * sext/zext(B), full A_WIDTH+B_WIDTH+1 bits.
  - Product is signed unless both UNSIGNED_A and UNSIGNED_B are 1.
  - term = SUBTRACT ? -prod : prod.
  - acc = LOAD_ACC ? term : acc + term, modulo 2^ACC_WIDTH (wraps; no sticky state).
  - Invalid beats hold acc and produce no VALID_OUT pulse.
- Stage 2, post-process:
  - r = acc + (ROUND && SHIFT_RIGHT>0 ? 1<<(SHIFT_RIGHT-1) : 0).
  - r >>= SHIFT_RIGHT: arithmetic when signed, logical when unsigned.
  - OVERFLOW[n] = r outside the Z_WIDTH signed range (signed) or above 2^Z_WIDTH-1 (unsigned).
  - SATURATE=1 clamps to the range limit. SATURATE=0 truncates to the low Z_WIDTH bits.
  - Registered when OUTPUT_REG_EN, otherwise combinational from acc.
- Latency VALID_IN to VALID_OUT = 1 + INPUT_REG_EN + OUTPUT_REG_EN cycles; default 3.
- Full throughput: one beat per cycle, no backpressure.
- Z and OVERFLOW hold their last values while VALID_OUT=0.
- SHIFT_RIGHT >= ACC_WIDTH is illegal; the result is 0 (unsigned) or sign fill (signed).
- Controls are shared by all lanes; lanes are otherwise independent.

Decomposition:
- Package dsp_multacc_pkg:
  - FEEDBACK encoding constants: FB_A=3'b000, FB_COEFF_BIT=2.
  - Saturation/range helper functions.
  - Stage-valid pipeline typedef.
- Sub-module dsp_multacc_lane: one lane's multiply, accumulator and post-process. Generated NUM_CH times under shared control and valid pipeline in the top.

Test Plan (defaults, latency 3):
- Reset: hold RESET=0 while driving operands -> Z=0, DLY_B=0, VALID_OUT=0, OVERFLOW=0; release, B lane0=9'd5 -> DLY_B lane0=5 one cycle later.
- Signed multiply: A lane0=10'h3FD (-3), B=5, FEEDBACK=0, LOAD_ACC=1, VALID_IN=1 -> 3 cycles later Z lane0=19'h7FFF1 (-15), VALID_OUT=1 for one cycle.
- Accumulate: A=10, B=10, LOAD_ACC=1 then 4 back-to-back beats LOAD_ACC=0, then 1 beat SUBTRACT=1 -> Z=100,200,300,400,500,400 on consecutive cycles. Inserting a VALID_IN=0 bubble holds the sequence with no extra VALID_OUT.
- Coefficient: COEFF lane1 k=2 = 7, FEEDBACK=3'b110, A lane1=123, B=9 -> Z lane1=63 (A ignored).
- Shift/round: acc=100, SHIFT_RIGHT=3 -> ROUND=1 gives Z=13; ROUND=0 gives Z=12.
- Saturation: UNSIGNED_A=UNSIGNED_B=1, A=1023, B=511, LOAD then accumulate once (acc=1045506) -> SATURATE=1: Z=19'h7FFFF, OVERFLOW=1; SATURATE=0: Z=521218, OVERFLOW=1. Assert RESET mid-sequence -> Z=0 immediately.

Source files
------------

// File: rtl/dsp_multacc_pkg.sv
// rtl/dsp_multacc_pkg.sv - shared types, feedback encoding and range helpers for the N-channel MAC
package dsp_multacc_pkg;

    localparam logic [2:0] FB_A         = 3'b000;
    localparam int         FB_COEFF_BIT = 2;

    // Beat controls captured together with the stage-0 valid
    typedef struct packed {
        logic       valid;
        logic [2:0] feedback;
        logic       load_acc;
        logic       unsigned_a;
        logic       unsigned_b;
        logic       subtract;
        logic [5:0] shift_right;
        logic       round;
        logic       saturate;
    } stage0_t;

    // Post-process controls travelling alongside the accumulator
    typedef struct packed {
        logic       valid;
        logic       signed_mode;
        logic [5:0] shift_right;
        logic       round;
        logic       saturate;
    } post_ctrl_t;

    function automatic longint range_max(input int w, input logic sgn);
        return sgn ? (64'sd1 <<< (w - 1)) - 64'sd1 : (64'sd1 <<< w) - 64'sd1;
    endfunction

    function automatic longint range_min(input int w, input logic sgn);
        return sgn ? -(64'sd1 <<< (w - 1)) : 64'sd0;
    endfunction

endpackage

// File: rtl/dsp_multacc_nch_if.sv
// rtl/dsp_multacc_nch_if.sv - operand, control and result bundle of the N-channel MAC
interface dsp_multacc_nch_if #(
    parameter int NUM_CH  = 2,
    parameter int A_WIDTH = 10,
    parameter int B_WIDTH = 9,
    parameter int Z_WIDTH = 19
);
    logic                        VALID_IN;
    logic [NUM_CH*A_WIDTH-1:0]   A;
    logic [NUM_CH*B_WIDTH-1:0]   B;
    logic [2:0]                  FEEDBACK;
    logic                        LOAD_ACC;
    logic                        UNSIGNED_A;
    logic                        UNSIGNED_B;
    logic                        SUBTRACT;
    logic [5:0]                  SHIFT_RIGHT;
    logic                        ROUND;
    logic                        SATURATE;
    logic [NUM_CH*Z_WIDTH-1:0]   Z;
    logic [NUM_CH*B_WIDTH-1:0]   DLY_B;
    logic                        VALID_OUT;
    logic [NUM_CH-1:0]           OVERFLOW;

    modport master (
        output VALID_IN, A, B, FEEDBACK, LOAD_ACC, UNSIGNED_A, UNSIGNED_B,
               SUBTRACT, SHIFT_RIGHT, ROUND, SATURATE,
        input  Z, DLY_B, VALID_OUT, OVERFLOW
    );

    modport slave (
        input  VALID_IN, A, B, FEEDBACK, LOAD_ACC, UNSIGNED_A, UNSIGNED_B,
               SUBTRACT, SHIFT_RIGHT, ROUND, SATURATE,
        output Z, DLY_B, VALID_OUT, OVERFLOW
    );
endinterface

// File: rtl/dsp_multacc_nch_lane.sv
// rtl/dsp_multacc_nch_lane.sv - one MAC lane: operand select, multiply, accumulator, round/shift/saturate
module dsp_multacc_lane
    import dsp_multacc_pkg::*;
#(
    parameter int                  A_WIDTH   = 10,
    parameter int                  B_WIDTH   = 9,
    parameter int                  Z_WIDTH   = 19,
    parameter int                  ACC_WIDTH = 32,
    parameter logic [4*A_WIDTH-1:0] COEFF    = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               acc_en,
    input  logic [2:0]         feedback,
    input  logic               load_acc,
    input  logic               unsigned_a,
    input  logic               unsigned_b,
    input  logic               subtract,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    input  logic               post_sign,
    input  logic [5:0]         shift_right,
    input  logic               round,
    input  logic               saturate,
    output logic [Z_WIDTH-1:0] z,
    output logic               overflow
);
    localparam int PW = A_WIDTH + B_WIDTH + 1;

    logic [A_WIDTH-1:0]   mult;
    logic [PW-1:0]        ma, mb, prod;
    logic [ACC_WIDTH-1:0] term, acc;
    logic                 prod_signed;

    always_comb begin
        mult        = feedback[FB_COEFF_BIT] ? COEFF[int'(feedback[1:0]) * A_WIDTH +: A_WIDTH] : a;
        prod_signed = !(unsigned_a && unsigned_b);
        ma          = {{(PW-A_WIDTH){mult[A_WIDTH-1] & ~unsigned_a}}, mult};
        mb          = {{(PW-B_WIDTH){b[B_WIDTH-1] & ~unsigned_b}}, b};
        prod        = ma * mb;
        term        = {{(ACC_WIDTH-PW){prod[PW-1] & prod_signed}}, prod};
        if (subtract) term = -term;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      acc <= '0;
        else if (acc_en) acc <= load_acc ? term : acc + term;
    end

    // Post-process in a 64-bit signed domain so rounding and range checks cannot wrap
    logic signed [63:0] ext, sum, r;
    logic               above, below;

    always_comb begin
        ext = {{(64-ACC_WIDTH){acc[ACC_WIDTH-1] & post_sign}}, acc};
        sum = ext;
        if (round && shift_right != 6'd0) sum = ext + (64'sd1 <<< (shift_right - 6'd1));
        if (int'(shift_right) >= ACC_WIDTH) r = post_sign ? {64{acc[ACC_WIDTH-1]}} : '0;
        else if (post_sign)                 r = sum >>> shift_right;
        else                                r = sum >> shift_right;
        above    = r > range_max(Z_WIDTH, post_sign);
        below    = r < range_min(Z_WIDTH, post_sign);
        overflow = above || below;
        if (saturate && above)      z = post_sign ? {1'b0, {(Z_WIDTH-1){1'b1}}} : '1;
        else if (saturate && below) z = {1'b1, {(Z_WIDTH-1){1'b0}}};
        else                        z = r[Z_WIDTH-1:0];
    end
endmodule

// File: rtl/dsp_multacc_nch.sv
// rtl/dsp_multacc_nch.sv - N-channel MAC top: input/output registers, shared control and valid pipeline
module dsp_multacc_nch
    import dsp_multacc_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int A_WIDTH       = 10,
    parameter int B_WIDTH       = 9,
    parameter int Z_WIDTH       = 19,
    parameter int ACC_WIDTH     = 32,
    parameter int INPUT_REG_EN  = 1,
    parameter int OUTPUT_REG_EN = 1,
    parameter logic [NUM_CH*4*A_WIDTH-1:0] COEFF = '0
) (
    input  logic             CLK,
    input  logic             RESET,
    dsp_multacc_nch_if.slave bus
);
    stage0_t                   s_in, s0;
    post_ctrl_t                p1;
    logic [NUM_CH*A_WIDTH-1:0] a0;
    logic [NUM_CH*B_WIDTH-1:0] b0, dly_b;
    logic [NUM_CH*Z_WIDTH-1:0] z_c;
    logic [NUM_CH-1:0]         ovf_c;

    always_comb begin
        s_in             = '0;
        s_in.valid       = bus.VALID_IN;
        s_in.feedback    = bus.FEEDBACK;
        s_in.load_acc    = bus.LOAD_ACC;
        s_in.unsigned_a  = bus.UNSIGNED_A;
        s_in.unsigned_b  = bus.UNSIGNED_B;
        s_in.subtract    = bus.SUBTRACT;
        s_in.shift_right = bus.SHIFT_RIGHT;
        s_in.round       = bus.ROUND;
        s_in.saturate    = bus.SATURATE;
    end

    if (INPUT_REG_EN != 0) begin : g_in_reg
        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                s0 <= '0;
                a0 <= '0;
                b0 <= '0;
            end else begin
                s0 <= s_in;
                a0 <= bus.A;
                b0 <= bus.B;
            end
        end
    end else begin : g_in_wire
        assign s0 = s_in;
        assign a0 = bus.A;
        assign b0 = bus.B;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) dly_b <= '0;
        else        dly_b <= bus.B;
    end
    assign bus.DLY_B = dly_b;

    // Post controls only advance with a valid beat, so Z holds across bubbles even unregistered
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            p1 <= '0;
        end else begin
            p1.valid <= s0.valid;
            if (s0.valid) begin
                p1.signed_mode <= !(s0.unsigned_a && s0.unsigned_b);
                p1.shift_right <= s0.shift_right;
                p1.round       <= s0.round;
                p1.saturate    <= s0.saturate;
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        dsp_multacc_lane #(
            .A_WIDTH   (A_WIDTH),
            .B_WIDTH   (B_WIDTH),
            .Z_WIDTH   (Z_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .COEFF     (COEFF[n*4*A_WIDTH +: 4*A_WIDTH])
        ) u_lane (
            .clk         (CLK),
            .rst_n       (RESET),
            .acc_en      (s0.valid),
            .feedback    (s0.feedback),
            .load_acc    (s0.load_acc),
            .unsigned_a  (s0.unsigned_a),
            .unsigned_b  (s0.unsigned_b),
            .subtract    (s0.subtract),
            .a           (a0[n*A_WIDTH +: A_WIDTH]),
            .b           (b0[n*B_WIDTH +: B_WIDTH]),
            .post_sign   (p1.signed_mode),
            .shift_right (p1.shift_right),
            .round       (p1.round),
            .saturate    (p1.saturate),
            .z           (z_c[n*Z_WIDTH +: Z_WIDTH]),
            .overflow    (ovf_c[n])
        );
    end

    if (OUTPUT_REG_EN != 0) begin : g_out_reg
        logic [NUM_CH*Z_WIDTH-1:0] z_q;
        logic [NUM_CH-1:0]         ovf_q;
        logic                      vout_q;

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                z_q    <= '0;
                ovf_q  <= '0;
                vout_q <= 1'b0;
            end else begin
                vout_q <= p1.valid;
                if (p1.valid) begin
                    z_q   <= z_c;
                    ovf_q <= ovf_c;
                end
            end
        end
        assign bus.Z         = z_q;
        assign bus.OVERFLOW  = ovf_q;
        assign bus.VALID_OUT = vout_q;
    end else begin : g_out_wire
        assign bus.Z         = z_c;
        assign bus.OVERFLOW  = ovf_c;
        assign bus.VALID_OUT = p1.valid;
    end
endmodule

// File: tb/tb_dsp_multacc_nch.sv
// tb/tb_dsp_multacc_nch.sv - scoreboard bench for dsp_multacc_nch with directed hand-computed vectors
module tb_dsp_multacc_nch;
    import dsp_multacc_pkg::*;

    localparam logic [79:0] TB_COEFF = 80'd7 << 60;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dsp_multacc_nch_if bus ();
    dsp_multacc_nch #(.COEFF(TB_COEFF)) dut (.CLK(clk), .RESET(rst_n), .bus(bus));

    typedef struct {
        int          id;
        logic [18:0] z0;
        logic [18:0] z1;
        logic [1:0]  ovf;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   nid   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && bus.VALID_OUT === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid_out: got 1 expected 0 at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                chk($sformatf("beat%0d_z0", e.id), bus.Z[18:0], e.z0);
                chk($sformatf("beat%0d_z1", e.id), bus.Z[37:19], e.z1);
                chk($sformatf("beat%0d_ovf", e.id), bus.OVERFLOW, e.ovf);
                chk($sformatf("beat%0d_latency", e.id), cyc - e.cyc, 3);
            end
        end
    end

    task automatic beat(input logic [9:0] a0, input logic [9:0] a1,
                        input logic [8:0] b0, input logic [8:0] b1, input logic ld,
                        input logic [18:0] z0, input logic [18:0] z1, input logic [1:0] ov);
        exp_t e;
        bus.A        = {a1, a0};
        bus.B        = {b1, b0};
        bus.LOAD_ACC = ld;
        bus.VALID_IN = 1'b1;
        e.id = nid; e.z0 = z0; e.z1 = z1; e.ovf = ov; e.cyc = cyc;
        nid++;
        q.push_back(e);
        @(posedge clk); #1;
        bus.VALID_IN = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.VALID_IN = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.FEEDBACK = FB_A; bus.UNSIGNED_A = 1'b0; bus.UNSIGNED_B = 1'b0;
        bus.SUBTRACT = 1'b0; bus.SHIFT_RIGHT = 6'd0; bus.ROUND = 1'b0; bus.SATURATE = 1'b0;
        bus.A = {10'd77, 10'd55}; bus.B = {9'd3, 9'd4}; bus.VALID_IN = 1'b1; bus.LOAD_ACC = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_z", bus.Z, 0);
        chk("rst_dly_b", bus.DLY_B, 0);
        chk("rst_valid_out", bus.VALID_OUT, 0);
        chk("rst_overflow", bus.OVERFLOW, 0);

        bus.VALID_IN = 1'b0;
        bus.B = {9'd0, 9'd5};
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("dly_b_lane0", bus.DLY_B[8:0], 5);
        @(posedge clk); #1;

        beat(10'h3FD, 10'h3FD, 9'd5, 9'd5, 1'b1, 19'h7FFF1, 19'h7FFF1, 2'b00);
        idle(3);

        beat(10'd10, 10'd10, 9'd10, 9'd10, 1'b1, 19'd100, 19'd100, 2'b00);
        beat(10'd10, 10'd10, 9'd10, 9'd10, 1'b0, 19'd200, 19'd200, 2'b00);
        beat(10'd10, 10'd10, 9'd10, 9'd10, 1'b0, 19'd300, 19'd300, 2'b00);
        idle(1);
        beat(10'd10, 10'd10, 9'd10, 9'd10, 1'b0, 19'd400, 19'd400, 2'b00);
        beat(10'd10, 10'd10, 9'd10, 9'd10, 1'b0, 19'd500, 19'd500, 2'b00);
        bus.SUBTRACT = 1'b1;
        beat(10'd10, 10'd10, 9'd10, 9'd10, 1'b0, 19'd400, 19'd400, 2'b00);
        bus.SUBTRACT = 1'b0;

        bus.FEEDBACK = 3'b110;
        beat(10'd123, 10'd123, 9'd9, 9'd9, 1'b1, 19'd0, 19'd63, 2'b00);
        bus.FEEDBACK = FB_A;

        bus.SHIFT_RIGHT = 6'd3; bus.ROUND = 1'b1;
        beat(10'd10, 10'd10, 9'd10, 9'd10, 1'b1, 19'd13, 19'd13, 2'b00);
        bus.ROUND = 1'b0;
        beat(10'd10, 10'd10, 9'd10, 9'd10, 1'b1, 19'd12, 19'd12, 2'b00);
        bus.SHIFT_RIGHT = 6'd40;
        beat(10'h3FD, 10'd10, 9'd5, 9'd10, 1'b1, 19'h7FFFF, 19'd0, 2'b00);
        bus.SHIFT_RIGHT = 6'd0;

        bus.SATURATE = 1'b1;
        beat(10'h200, 10'h200, 9'h100, 9'h0FF, 1'b1, 19'h20000, 19'h60200, 2'b00);
        beat(10'h200, 10'h200, 9'h100, 9'h0FF, 1'b0, 19'h3FFFF, 19'h40400, 2'b01);
        beat(10'h200, 10'h200, 9'h100, 9'h0FF, 1'b0, 19'h3FFFF, 19'h40000, 2'b11);

        bus.UNSIGNED_A = 1'b1; bus.UNSIGNED_B = 1'b1;
        beat(10'd1023, 10'd1023, 9'd511, 9'd511, 1'b1, 19'd522753, 19'd522753, 2'b00);
        beat(10'd1023, 10'd1023, 9'd511, 9'd511, 1'b0, 19'h7FFFF, 19'h7FFFF, 2'b11);
        bus.SATURATE = 1'b0;
        beat(10'd1023, 10'd1023, 9'd511, 9'd511, 1'b1, 19'd522753, 19'd522753, 2'b00);
        beat(10'd1023, 10'd1023, 9'd511, 9'd511, 1'b0, 19'd521218, 19'd521218, 2'b11);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        idle(2);
        chk("queue_drained", q.size(), 0);
        chk("hold_z", bus.Z, {19'd521218, 19'd521218});
        chk("hold_overflow", bus.OVERFLOW, 2'b11);

        bus.A = {10'd3, 10'd3}; bus.B = {9'd3, 9'd3}; bus.LOAD_ACC = 1'b1; bus.VALID_IN = 1'b1;
        @(posedge clk); #1;
        bus.VALID_IN = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_z", bus.Z, 0);
        chk("midrst_overflow", bus.OVERFLOW, 0);
        chk("midrst_valid_out", bus.VALID_OUT, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
